// File: rtl/bit_packer.sv
// bit_packer
//   Repacks a stream of variable-length chunks (0..CHUNK_WIDTH bits) into
//   dense WORD_WIDTH-bit words, MSB-first. When a flush is requested, any
//   partial word is drained, zero-padded, together with its valid-bit count.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   pushin   in   chunk valid (ignored while busy)
//   lenin    in   chunk length, 0..CHUNK_WIDTH
//   datain   in   chunk bits, LSB-aligned; bits at or above lenin are ignored
//   flush    in   drain request (ignored while busy)
//   pushout  out  one-cycle word-valid pulse
//   dataout  out  packed word; the earliest bit is at the MSB
//   lenout   out  valid bits in dataout (WORD_WIDTH for a full word)
//   busy     out  registered; high for the single DRAIN cycle
module bit_packer #(
    parameter int WORD_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 15,
    parameter int LEN_WIDTH   = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              pushin,
    input  logic [LEN_WIDTH-1:0]              lenin,
    input  logic [CHUNK_WIDTH-1:0]            datain,
    input  logic                              flush,
    output logic                              pushout,
    output logic [WORD_WIDTH-1:0]             dataout,
    output logic [$clog2(WORD_WIDTH+1)-1:0]   lenout,
    output logic                              busy
);
    // The worst case is WORD_WIDTH-1 leftover bits plus one full chunk.
    localparam int ACC_W = WORD_WIDTH + CHUNK_WIDTH - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int LO_W  = $clog2(WORD_WIDTH + 1);

    localparam logic [0:0] ST_ACC   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]             state_q,   state_d;
    logic [ACC_W-1:0]       acc_q,     acc_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   pushout_q, pushout_d;
    logic [WORD_WIDTH-1:0]  dataout_q, dataout_d;
    logic [LO_W-1:0]        lenout_q,  lenout_d;

    logic [CNT_W-1:0]       push_len;
    logic [CHUNK_WIDTH-1:0] chunk_mask;
    logic [ACC_W-1:0]       chunk_ext;
    logic [ACC_W-1:0]       acc_new;
    logic [CNT_W-1:0]       total;

    always_comb begin
        // Length 0 also models "no push", so a bare flush uses the same path.
        push_len   = pushin ? CNT_W'(lenin) : '0;
        // Wraps to all ones for a full-width chunk.
        chunk_mask = CHUNK_WIDTH'((CHUNK_WIDTH+1)'(1) << lenin) - CHUNK_WIDTH'(1);
        chunk_ext  = ACC_W'(datain & chunk_mask);
        // Left-align the chunk at the top, then slide it just below the cnt
        // bits already held. A zero length shifts everything out.
        chunk_ext  = (chunk_ext << (CNT_W'(ACC_W) - push_len)) >> cnt_q;
        acc_new    = acc_q | chunk_ext;
        total      = cnt_q + push_len;

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        pushout_d = 1'b0;
        dataout_d = dataout_q;
        lenout_d  = lenout_q;

        if (state_q == ST_DRAIN) begin
            // The bits left behind by a flushed full word; the upper bound
            // on total guarantees this fits in one partial word.
            pushout_d = 1'b1;
            dataout_d = acc_q[ACC_W-1 -: WORD_WIDTH];
            lenout_d  = LO_W'(cnt_q);
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = ST_ACC;
        end else if (flush && total != '0) begin
            pushout_d = 1'b1;
            dataout_d = acc_new[ACC_W-1 -: WORD_WIDTH];
            if (total <= CNT_W'(WORD_WIDTH)) begin
                lenout_d = LO_W'(total);
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                lenout_d = LO_W'(WORD_WIDTH);
                acc_d    = acc_new << WORD_WIDTH;
                cnt_d    = total - CNT_W'(WORD_WIDTH);
                state_d  = ST_DRAIN;
            end
        end else if (total >= CNT_W'(WORD_WIDTH)) begin
            pushout_d = 1'b1;
            dataout_d = acc_new[ACC_W-1 -: WORD_WIDTH];
            lenout_d  = LO_W'(WORD_WIDTH);
            acc_d     = acc_new << WORD_WIDTH;
            cnt_d     = total - CNT_W'(WORD_WIDTH);
        end else begin
            acc_d = acc_new;
            cnt_d = total;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            pushout_q <= 1'b0;
            dataout_q <= '0;
            lenout_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pushout_q <= pushout_d;
            dataout_q <= dataout_d;
            lenout_q  <= lenout_d;
        end
    end

    assign pushout = pushout_q;
    assign dataout = dataout_q;
    assign lenout  = lenout_q;
    assign busy    = (state_q == ST_DRAIN);
endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: every scenario task drives its stimulus and
// checks outputs one time unit after the clock edge that registers them.
module tb_bit_packer;
    logic        clock = 1'b0;
    logic        reset;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flush;
    logic        pushout;
    logic [31:0] dataout;
    logic [5:0]  lenout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    bit_packer dut (
        .clock  (clock),
        .reset  (reset),
        .pushin (pushin),
        .lenin  (lenin),
        .datain (datain),
        .flush  (flush),
        .pushout(pushout),
        .dataout(dataout),
        .lenout (lenout),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    // Apply the current inputs at the next rising edge, then settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
        pushin = p; lenin = l; datain = d; flush = f;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL reset_pushout: got %b want 0", pushout); end
        n_cmp++; if (dataout !== 32'h0) begin n_bad++; $display("FAIL reset_dataout: got %h want 00000000", dataout); end
        n_cmp++; if (lenout !== 6'd0) begin n_bad++; $display("FAIL reset_lenout: got %0d want 0", lenout); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_bytes();
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'd8, 15'h0AB, 0);
            tick();
            if (i < 3) begin
                n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL bytes_early_push%0d: got %b want 0", i, pushout); end
            end
        end
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1) begin n_bad++; $display("FAIL bytes_pushout: got %b want 1", pushout); end
        n_cmp++; if (dataout !== 32'hABABABAB) begin n_bad++; $display("FAIL bytes_data: got %h want ABABABAB", dataout); end
        n_cmp++; if (lenout !== 6'd32) begin n_bad++; $display("FAIL bytes_len: got %0d want 32", lenout); end
        tick();
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL bytes_single_pulse: got %b want 0", pushout); end
        n_cmp++; if (dataout !== 32'hABABABAB) begin n_bad++; $display("FAIL bytes_data_hold: got %h want ABABABAB", dataout); end
    endtask

    task automatic test_fifteen();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd15, 15'h7FFF, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFFFFFFF || lenout !== 6'd32) begin
            n_bad++; $display("FAIL fifteen_word: got %b/%h/%0d want 1/FFFFFFFF/32", pushout, dataout, lenout); end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFF80000 || lenout !== 6'd13) begin
            n_bad++; $display("FAIL fifteen_flush: got %b/%h/%0d want 1/FFF80000/13", pushout, dataout, lenout); end
        tick();
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL fifteen_after: got %b want 0", pushout); end
    endtask

    task automatic test_mask();
        drive(1, 4'd5, 15'h7FF5, 0);
        tick();
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL mask_nopush: got %b want 0", pushout); end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hA8000000 || lenout !== 6'd5) begin
            n_bad++; $display("FAIL mask_flush: got %b/%h/%0d want 1/A8000000/5", pushout, dataout, lenout); end
        tick();
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL mask_single: got %b want 0", pushout); end
    endtask

    task automatic test_flush32();
        // Exactly one full word on flush, with no trailing partial.
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd8, 15'h0CD, 0);
            tick();
        end
        drive(1, 4'd8, 15'h0CD, 1);
        tick();
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hCDCDCDCD || lenout !== 6'd32 || busy !== 1'b0) begin
            n_bad++; $display("FAIL flush32_word: got %b/%h/%0d/%b want 1/CDCDCDCD/32/0", pushout, dataout, lenout, busy); end
        tick();
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL flush32_no_partial: got %b want 0", pushout); end
    endtask

    task automatic test_drain();
        drive(1, 4'd15, 15'h7FFF, 0); tick();
        drive(1, 4'd15, 15'h7FFF, 0); tick();
        drive(1, 4'd10, 15'h03FF, 1); tick();
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFFFFFFFF || lenout !== 6'd32 || busy !== 1'b1) begin
            n_bad++; $display("FAIL drain_word: got %b/%h/%0d/%b want 1/FFFFFFFF/32/1", pushout, dataout, lenout, busy); end
        // Offered during busy: must be dropped.
        drive(1, 4'd15, 15'h7FFF, 0); tick();
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hFF000000 || lenout !== 6'd8 || busy !== 1'b0) begin
            n_bad++; $display("FAIL drain_partial: got %b/%h/%0d/%b want 1/FF000000/8/0", pushout, dataout, lenout, busy); end
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL drain_empty_flush: got %b want 0", pushout); end
    endtask

    task automatic test_zero();
        int seen = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd0, 15'h7FFF, 0); tick();
            if (pushout !== 1'b0 || busy !== 1'b0) seen++;
        end
        drive(1, 4'd0, 15'h7FFF, 1); tick();
        if (pushout !== 1'b0 || busy !== 1'b0) seen++;
        drive(0, 0, 0, 1); tick();
        if (pushout !== 1'b0 || busy !== 1'b0) seen++;
        drive(0, 0, 0, 0);
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL zero_len: got %0d cycles with pushout/busy want 0", seen); end
    endtask

    task automatic test_reset_drain();
        drive(1, 4'd15, 15'h7FFF, 0); tick();
        drive(1, 4'd15, 15'h7FFF, 0); tick();
        drive(1, 4'd10, 15'h03FF, 1); tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b want 1", busy); end
        drive(0, 0, 0, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (pushout !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rd_reset: got pushout %b busy %b want 0 0", pushout, busy); end
        drive(1, 4'd15, 15'h5555, 0); tick();
        drive(1, 4'd15, 15'h5555, 0); tick();
        n_cmp++; if (pushout !== 1'b0) begin n_bad++; $display("FAIL rd_stale_early: got %b want 0", pushout); end
        drive(1, 4'd15, 15'h5555, 0); tick();
        drive(0, 0, 0, 0);
        n_cmp++; if (pushout !== 1'b1 || dataout !== 32'hAAAB5556 || lenout !== 6'd32) begin
            n_bad++; $display("FAIL rd_first_word: got %b/%h/%0d want 1/AAAB5556/32", pushout, dataout, lenout); end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        test_reset();
        test_bytes();
        test_fifteen();
        test_mask();
        test_flush32();
        test_drain();
        test_zero();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
